pulse_train_generator: RTL and testbench

Generates a bounded train of clean, clock-synchronous pulses with programmable high width, low width and count. It is the transmit-side counterpart to the pulse and edge detection blocks in the sequential library. It drives stimulus and strobe lines that downstream detectors, synchronizers and counters consume. The block is started by a single-cycle command and reports completion with a one-cycle `done` strobe.

---
 rtl/pulse_train_generator_if.sv | 36 +++
 rtl/pulse_train_generator.sv | 111 +++++++++++
 tb/tb_pulse_train_generator.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_generator_if.sv
// Command and status bundle for pulse_train_generator.
// The optional abort line exists only when PULSE_TRAIN_ABORT_EN is defined.
interface pulse_train_generator_if #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
);
  logic             start;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [NUM_W-1:0] num_pulses;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulses_sent;
`ifdef PULSE_TRAIN_ABORT_EN
  logic             abort;

  modport master (
    output start, high_cycles, low_cycles, num_pulses, abort,
    input  pulse_out, busy, done, pulses_sent
  );
  modport slave (
    input  start, high_cycles, low_cycles, num_pulses, abort,
    output pulse_out, busy, done, pulses_sent
  );
`else
  modport master (
    output start, high_cycles, low_cycles, num_pulses,
    input  pulse_out, busy, done, pulses_sent
  );
  modport slave (
    input  start, high_cycles, low_cycles, num_pulses,
    output pulse_out, busy, done, pulses_sent
  );
`endif
endinterface

// File: rtl/pulse_train_generator.sv
// Emits N pulses of H high / L low cycles after a start strobe, then a one-cycle done.
// Define PULSE_TRAIN_ABORT_EN to add an abort input that cancels a running train.
module pulse_train_generator #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  pulse_train_generator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phaseCnt_q, phaseCnt_d;
  logic [CNT_W-1:0] highLen_q, highLen_d;
  logic [CNT_W-1:0] lowLen_q, lowLen_d;
  logic [NUM_W-1:0] numPulses_q, numPulses_d;
  logic [NUM_W-1:0] pulsesSent_q, pulsesSent_d;
  logic             done_q, done_d;

  // Phase counters count down to zero; a zero length behaves as one cycle.
  function automatic logic [CNT_W-1:0] phaseLoad(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    phaseCnt_d   = phaseCnt_q;
    highLen_d    = highLen_q;
    lowLen_d     = lowLen_q;
    numPulses_d  = numPulses_q;
    pulsesSent_d = pulsesSent_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          highLen_d    = bus.high_cycles;
          lowLen_d     = bus.low_cycles;
          numPulses_d  = bus.num_pulses;
          pulsesSent_d = '0;
          if (bus.num_pulses != '0) begin
            state_d    = HIGH;
            phaseCnt_d = phaseLoad(bus.high_cycles);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      HIGH: begin
        if (phaseCnt_q == '0) begin
          pulsesSent_d = pulsesSent_q + 1'b1;
          if (pulsesSent_d == numPulses_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = LOW;
            phaseCnt_d = phaseLoad(lowLen_q);
          end
        end else begin
          phaseCnt_d = phaseCnt_q - 1'b1;
        end
      end
      LOW: begin
        if (phaseCnt_q == '0) begin
          state_d    = HIGH;
          phaseCnt_d = phaseLoad(highLen_q);
        end else begin
          phaseCnt_d = phaseCnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PULSE_TRAIN_ABORT_EN
    // Abort cancels silently and keeps the count of pulses already finished.
    if (bus.abort && state_q != IDLE) begin
      state_d      = IDLE;
      done_d       = 1'b0;
      pulsesSent_d = pulsesSent_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phaseCnt_q   <= '0;
      highLen_q    <= '0;
      lowLen_q     <= '0;
      numPulses_q  <= '0;
      pulsesSent_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phaseCnt_q   <= phaseCnt_d;
      highLen_q    <= highLen_d;
      lowLen_q     <= lowLen_d;
      numPulses_q  <= numPulses_d;
      pulsesSent_q <= pulsesSent_d;
      done_q       <= done_d;
    end
  end

  assign bus.pulse_out   = (state_q == HIGH);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.pulses_sent = pulsesSent_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed testbench for pulse_train_generator; abort scenario runs when PULSE_TRAIN_ABORT_EN is defined.
module tb_pulse_train_generator;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failures = 0;

  pulse_train_generator_if #(.CNT_W(8), .NUM_W(8)) busIf ();

  pulse_train_generator #(.CNT_W(8), .NUM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  // Observations are taken 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] n, input logic [7:0] h,
                               input logic [7:0] l);
    busIf.start       = s;
    busIf.num_pulses  = n;
    busIf.high_cycles = h;
    busIf.low_cycles  = l;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    reset = 1'b1;
    applyStimulus(1'b1, 8'd3, 8'd2, 8'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      obs = {busIf.pulse_out, busIf.busy, busIf.done, busIf.pulses_sent};
      tests++;
      if (obs !== 11'd0) begin
        failures++;
        $display("[TB] FAIL reset cycle %0d: got %b expected %b", i, obs, 11'd0);
      end
    end
    reset = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    tick();
  endtask

  task automatic test_basic();
    logic [10:0] obs, exp;
    logic [8:0]  pulseExp = 9'b011011011;
    int          sentExp[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
    applyStimulus(1'b1, 8'd3, 8'd2, 8'd1);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      if (i < 9)
        exp = {pulseExp[i], (i < 8) ? 1'b1 : 1'b0, (i == 8) ? 1'b1 : 1'b0, 8'(sentExp[i])};
      else
        exp = {1'b0, 1'b0, 1'b0, 8'd3};
      obs = {busIf.pulse_out, busIf.busy, busIf.done, busIf.pulses_sent};
      tests++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL basic cycle k+%0d: got %b expected %b", i + 1, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_zero_count();
    logic [10:0] obs;
    applyStimulus(1'b1, 8'd0, 8'd4, 8'd4);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    obs = {busIf.pulse_out, busIf.busy, busIf.done, busIf.pulses_sent};
    tests++;
    if (obs !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
      failures++;
      $display("[TB] FAIL zero_count k+1: got %b expected %b", obs, {1'b0, 1'b0, 1'b1, 8'd0});
    end
    tick();
    obs = {busIf.pulse_out, busIf.busy, busIf.done, busIf.pulses_sent};
    tests++;
    if (obs !== 11'd0) begin
      failures++;
      $display("[TB] FAIL zero_count k+2: got %b expected %b", obs, 11'd0);
    end
  endtask

  task automatic test_zero_widths();
    logic [10:0] obs, exp;
    logic [3:0]  pulseExp = 4'b0101;
    int          sentExp[4] = '{0, 1, 1, 2};
    applyStimulus(1'b1, 8'd2, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      exp = {pulseExp[i], (i < 3) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0, 8'(sentExp[i])};
      obs = {busIf.pulse_out, busIf.busy, busIf.done, busIf.pulses_sent};
      tests++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL zero_widths cycle k+%0d: got %b expected %b", i + 1, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_ignored_start();
    logic [6:0] pulseExp = 7'b0110011;
    int         doneCount = 0;
    applyStimulus(1'b1, 8'd2, 8'd2, 8'd2);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      if (i >= 1 && i <= 3) applyStimulus(1'b1, 8'd5, 8'd1, 8'd1);
      else applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
      tests++;
      if (i < 7 && busIf.pulse_out !== pulseExp[i]) begin
        failures++;
        $display("[TB] FAIL ignored_start pulse k+%0d: got %b expected %b", i + 1,
                 busIf.pulse_out, pulseExp[i]);
      end else if (i >= 7 && busIf.busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL ignored_start busy k+%0d: got %b expected 0", i + 1, busIf.busy);
      end
      if (busIf.done === 1'b1) doneCount++;
      tick();
    end
    tests++;
    if (doneCount != 1) begin
      failures++;
      $display("[TB] FAIL ignored_start done count: got %0d expected 1", doneCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs, exp;
    logic [5:0]  pulseExp = 6'b010101;
    logic [5:0]  busyExp  = 6'b011101;
    logic [5:0]  doneExp  = 6'b100010;
    int          sentExp[6] = '{0, 1, 0, 1, 1, 2};
    applyStimulus(1'b1, 8'd1, 8'd1, 8'd9);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      exp = {pulseExp[i], busyExp[i], doneExp[i], 8'(sentExp[i])};
      obs = {busIf.pulse_out, busIf.busy, busIf.done, busIf.pulses_sent};
      tests++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", i + 1, obs, exp);
      end
      if (i == 1) applyStimulus(1'b1, 8'd2, 8'd1, 8'd1);
      else applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs;
    applyStimulus(1'b1, 8'd4, 8'd3, 8'd3);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    repeat (7) tick();
    tests++;
    if (busIf.pulse_out !== 1'b1 || busIf.pulses_sent !== 8'd1) begin
      failures++;
      $display("[TB] FAIL reset_mid second pulse: got pulse=%b sent=%0d expected pulse=1 sent=1",
               busIf.pulse_out, busIf.pulses_sent);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    obs = {busIf.pulse_out, busIf.busy, busIf.done, busIf.pulses_sent};
    tests++;
    if (obs !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid after reset: got %b expected %b", obs, 11'd0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (busIf.done !== 1'b0 || busIf.busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_mid quiet %0d: got done=%b busy=%b expected 0 0", i,
                 busIf.done, busIf.busy);
      end
    end
  endtask

`ifdef PULSE_TRAIN_ABORT_EN
  task automatic test_abort();
    logic [10:0] obs, exp;
    logic [3:0]  pulseExp = 4'b0011;
    logic [3:0]  busyExp  = 4'b0011;
    logic [3:0]  doneExp  = 4'b0100;
    applyStimulus(1'b1, 8'd4, 8'd2, 8'd2);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    repeat (8) tick();
    tests++;
    if (busIf.pulse_out !== 1'b1 || busIf.pulses_sent !== 8'd2) begin
      failures++;
      $display("[TB] FAIL abort third high: got pulse=%b sent=%0d expected pulse=1 sent=2",
               busIf.pulse_out, busIf.pulses_sent);
    end
    busIf.abort = 1'b1;
    tick();
    obs = {busIf.pulse_out, busIf.busy, busIf.done, busIf.pulses_sent};
    tests++;
    if (obs !== {1'b0, 1'b0, 1'b0, 8'd2}) begin
      failures++;
      $display("[TB] FAIL abort result: got %b expected %b", obs, {1'b0, 1'b0, 1'b0, 8'd2});
    end
    applyStimulus(1'b1, 8'd1, 8'd2, 8'd0);
    tick();
    busIf.abort = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      exp = {pulseExp[i], busyExp[i], doneExp[i], (i >= 2) ? 8'd1 : 8'd0};
      obs = {busIf.pulse_out, busIf.busy, busIf.done, busIf.pulses_sent};
      tests++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL abort restart cycle %0d: got %b expected %b", i + 1, obs, exp);
      end
      tick();
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
`ifdef PULSE_TRAIN_ABORT_EN
    busIf.abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero_count();
    test_zero_widths();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
`ifdef PULSE_TRAIN_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
